// File: rtl/sap_core_param.sv
// ---------------------------------------------------------------------------
// sap_core_param
//
// Parametrised hardwired SAP-class processor. Fixed six T-states per
// instruction, single-port program RAM loadable by a host while the core is
// idle or halted.
//
// Parameters
//   DATA_W : width of RAM words, ACC, B and OUT (must be >= 4 + ADDR_W)
//   ADDR_W : address width, RAM depth = 2**ADDR_W
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   prog_we    host RAM write strobe (IDLE/HALT only)
//   prog_addr  host RAM write address
//   prog_data  host RAM write data
//   run        start pulse (IDLE/HALT only)
//   busy       high while running
//   halted     high while halted
//   out_valid  one-cycle strobe when out_data is loaded by OUT
//   out_data   output register
//   pc         program counter
//   t_state    one-hot T-state ring (bit0 = T1), zero outside RUN
//   acc        accumulator
//   flag_z     zero flag
//   flag_c     carry flag (1 on SUB means no borrow)
// ---------------------------------------------------------------------------
module sap_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    output logic              busy,
    output logic              halted,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] pc,
    output logic [5:0]        t_state,
    output logic [DATA_W-1:0] acc,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2
    } mode_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int DEPTH = 2 ** ADDR_W;

    // Architectural state
    mode_t             mode_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] b_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [3:0]        ir_op_reg;   // opcode field of IR
    logic [ADDR_W-1:0] ir_arg_reg;  // operand field of IR; middle bits are don't-care
    logic [DATA_W-1:0] out_data_reg;
    logic [5:0]        t_state_reg;
    logic              flag_z_reg;
    logic              flag_c_reg;
    logic              out_valid_reg;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Combinational datapath
    logic [DATA_W-1:0] ram_rd;
    logic              is_run;
    logic              host_wr_en;
    logic              sta_wr_en;
    logic              is_sub;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] operand_ext;

    assign ram_rd      = mem_reg[mar_reg];
    assign is_run      = (mode_reg == MODE_RUN);
    assign host_wr_en  = prog_we && !is_run;
    assign sta_wr_en   = is_run && t_state_reg[4] && (ir_op_reg == OP_STA);

    // SUB is acc + ~B + 1, so the carry out doubles as "no borrow".
    assign is_sub      = (ir_op_reg == OP_SUB);
    assign alu_b       = is_sub ? ~b_reg : b_reg;
    assign alu_sum     = {1'b0, acc_reg} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};
    assign operand_ext = {{(DATA_W - ADDR_W){1'b0}}, ir_arg_reg};

    // Program RAM: single write port shared by host and STA. The two sources
    // are mutually exclusive because host writes are gated off in RUN.
    always_ff @(posedge clk) begin
        if (host_wr_en) begin
            mem_reg[prog_addr] <= prog_data;
        end else if (sta_wr_en) begin
            mem_reg[mar_reg] <= acc_reg;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg      <= MODE_IDLE;
            pc_reg        <= '0;
            acc_reg       <= '0;
            b_reg         <= '0;
            mar_reg       <= '0;
            ir_op_reg     <= '0;
            ir_arg_reg    <= '0;
            out_data_reg  <= '0;
            t_state_reg   <= '0;
            flag_z_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (mode_reg)
                MODE_IDLE, MODE_HALT: begin
                    if (run) begin
                        mode_reg    <= MODE_RUN;
                        pc_reg      <= '0;
                        acc_reg     <= '0;
                        flag_z_reg  <= 1'b0;
                        flag_c_reg  <= 1'b0;
                        t_state_reg <= 6'b000001;
                    end
                end

                MODE_RUN: begin
                    t_state_reg <= {t_state_reg[4:0], t_state_reg[5]};

                    if (t_state_reg[0]) begin
                        mar_reg <= pc_reg;
                    end

                    if (t_state_reg[1]) begin
                        pc_reg <= pc_reg + 1'b1;
                    end

                    if (t_state_reg[2]) begin
                        ir_op_reg  <= ram_rd[DATA_W-1 -: 4];
                        ir_arg_reg <= ram_rd[ADDR_W-1:0];
                    end

                    if (t_state_reg[3]) begin
                        case (ir_op_reg)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                mar_reg <= ir_arg_reg;
                            end
                            OP_LDI: begin
                                acc_reg    <= operand_ext;
                                flag_z_reg <= (operand_ext == '0);
                            end
                            OP_JMP: begin
                                pc_reg <= ir_arg_reg;
                            end
                            OP_JZ: begin
                                if (flag_z_reg) begin
                                    pc_reg <= ir_arg_reg;
                                end
                            end
                            OP_JC: begin
                                if (flag_c_reg) begin
                                    pc_reg <= ir_arg_reg;
                                end
                            end
                            OP_OUT: begin
                                out_data_reg  <= acc_reg;
                                out_valid_reg <= 1'b1;   // visible for the T5 cycle
                            end
                            OP_HLT: begin
                                // Overrides the ring advance above
                                mode_reg    <= MODE_HALT;
                                t_state_reg <= '0;
                            end
                            default: begin
                            end
                        endcase
                    end

                    if (t_state_reg[4]) begin
                        case (ir_op_reg)
                            OP_LDA: begin
                                acc_reg    <= ram_rd;
                                flag_z_reg <= (ram_rd == '0);
                            end
                            OP_ADD, OP_SUB: begin
                                b_reg <= ram_rd;
                            end
                            default: begin
                            end
                        endcase
                    end

                    if (t_state_reg[5]) begin
                        if (ir_op_reg == OP_ADD || ir_op_reg == OP_SUB) begin
                            {flag_c_reg, acc_reg} <= alu_sum;
                            flag_z_reg            <= (alu_sum[DATA_W-1:0] == '0);
                        end
                    end
                end

                default: begin
                    mode_reg    <= MODE_IDLE;
                    t_state_reg <= '0;
                end
            endcase
        end
    end

    assign busy      = is_run;
    assign halted    = (mode_reg == MODE_HALT);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign pc        = pc_reg;
    assign t_state   = t_state_reg;
    assign acc       = acc_reg;
    assign flag_z    = flag_z_reg;
    assign flag_c    = flag_c_reg;

endmodule
